// File: rtl/pong_pkg.sv
// Shared match-state types and screen constants for the pong endgame path.
package pong_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        PLAY           = 2'd0,
        ENDGAME_SCROLL = 2'd1,
        ENDGAME_HOLD   = 2'd2,
        WAIT_RESTART   = 2'd3
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

// File: rtl/banner_scroller.sv
// Banner y origin (saturating per-frame scroll) and endgame hold-frame counter.
// BANNER_SCROLL_EN enables the scroll; otherwise start loads the rest position.
module banner_scroller
    import pong_pkg::*;
#(
    parameter int unsigned BANNER_Y_START = 0,
    parameter int unsigned BANNER_Y_END   = 200,
`ifdef BANNER_SCROLL_EN
    parameter int unsigned SCROLL_STEP    = 4,
`endif
    parameter int unsigned HOLD_FRAMES    = 120
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   rearm,
    input  logic   frame_tick,
`ifdef BANNER_SCROLL_EN
    input  logic   scroll_en,
    output logic   scroll_done_c,
`endif
    input  logic   hold_en,
    output logic   hold_done_c,
    output coord_t start_y
);

    localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    coord_t            start_y_q, start_y_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

`ifdef BANNER_SCROLL_EN
    logic [COORD_W:0] y_sum;
    coord_t           y_step;
`endif

    always_comb begin
        start_y_d   = start_y_q;
        hold_d      = hold_q;
        hold_done_c = 1'b0;
`ifdef BANNER_SCROLL_EN
        scroll_done_c = 1'b0;
        // One extra bit keeps the step from wrapping before saturation.
        y_sum  = {1'b0, start_y_q} + (COORD_W+1)'(SCROLL_STEP);
        y_step = (y_sum >= (COORD_W+1)'(BANNER_Y_END)) ? coord_t'(BANNER_Y_END) : y_sum[COORD_W-1:0];
`endif
        if (start) begin
`ifdef BANNER_SCROLL_EN
            start_y_d = coord_t'(BANNER_Y_START);
`else
            start_y_d = coord_t'(BANNER_Y_END);
`endif
            hold_d = '0;
        end else if (rearm) begin
            start_y_d = coord_t'(BANNER_Y_START);
            hold_d    = '0;
`ifdef BANNER_SCROLL_EN
        end else if (scroll_en && frame_tick) begin
            start_y_d = y_step;
            if (y_step == coord_t'(BANNER_Y_END)) begin
                scroll_done_c = 1'b1;
                hold_d        = '0;
            end
`endif
        end else if (hold_en && frame_tick) begin
            if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
                hold_done_c = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_y_q <= coord_t'(BANNER_Y_START);
            hold_q    <= '0;
        end else begin
            start_y_q <= start_y_d;
            hold_q    <= hold_d;
        end
    end

    assign start_y = start_y_q;

endmodule

// File: rtl/endgame_controller.sv
// Match-state controller: scores, winner detection and endgame banner drive.
// BANNER_SCROLL_EN adds the ENDGAME_SCROLL animation; without it the banner jumps to rest.
module endgame_controller
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE      = 5,
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned BANNER_X       = 240,
    parameter int unsigned BANNER_Y_START = 0,
    parameter int unsigned BANNER_Y_END   = 200,
`ifdef BANNER_SCROLL_EN
    parameter int unsigned SCROLL_STEP    = 4,
`endif
    parameter int unsigned HOLD_FRAMES    = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               point_p1,
    input  logic               point_p2,
    input  logic               restart,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               game_active,
    output logic               endgame_active,
    output logic [1:0]         who_win,
    output logic [9:0]         start_x,
    output logic [9:0]         start_y
);

`ifdef BANNER_SCROLL_EN
    localparam state_e WIN_STATE = ENDGAME_SCROLL;
    logic scroll_done_c;
`else
    localparam state_e WIN_STATE = ENDGAME_HOLD;
`endif

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
    logic [SCORE_W-1:0] p1_inc, p2_inc;
    logic [1:0]         who_win_q, who_win_d;
    logic               game_active_q, game_active_d;
    logic               endgame_active_q, endgame_active_d;
    logic               win_start, rearm, hold_done_c;

    // Next-state, score and winner logic.
    always_comb begin
        state_d    = state_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        who_win_d  = who_win_q;
        win_start  = 1'b0;
        rearm      = 1'b0;
        p1_inc     = score_p1_q + SCORE_W'(1);
        p2_inc     = score_p2_q + SCORE_W'(1);

        unique case (state_q)
            PLAY: begin
                if (restart) begin
                    score_p1_d = '0;
                    score_p2_d = '0;
                end else if (point_p1 && !point_p2) begin
                    score_p1_d = p1_inc;
                    if (p1_inc == SCORE_W'(WIN_SCORE)) begin
                        who_win_d = WIN_P1;
                        win_start = 1'b1;
                        state_d   = WIN_STATE;
                    end
                end else if (point_p2 && !point_p1) begin
                    score_p2_d = p2_inc;
                    if (p2_inc == SCORE_W'(WIN_SCORE)) begin
                        who_win_d = WIN_P2;
                        win_start = 1'b1;
                        state_d   = WIN_STATE;
                    end
                end
            end
`ifdef BANNER_SCROLL_EN
            ENDGAME_SCROLL: begin
                if (scroll_done_c) state_d = ENDGAME_HOLD;
            end
`endif
            ENDGAME_HOLD: begin
                if (hold_done_c) state_d = WAIT_RESTART;
            end
            WAIT_RESTART: begin
                if (restart) begin
                    score_p1_d = '0;
                    score_p2_d = '0;
                    who_win_d  = WIN_NONE;
                    rearm      = 1'b1;
                    state_d    = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase

        game_active_d    = (state_d == PLAY);
        endgame_active_d = (state_d != PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= PLAY;
            score_p1_q       <= '0;
            score_p2_q       <= '0;
            who_win_q        <= WIN_NONE;
            game_active_q    <= 1'b1;
            endgame_active_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            score_p1_q       <= score_p1_d;
            score_p2_q       <= score_p2_d;
            who_win_q        <= who_win_d;
            game_active_q    <= game_active_d;
            endgame_active_q <= endgame_active_d;
        end
    end

    banner_scroller #(
        .BANNER_Y_START (BANNER_Y_START),
        .BANNER_Y_END   (BANNER_Y_END),
`ifdef BANNER_SCROLL_EN
        .SCROLL_STEP    (SCROLL_STEP),
`endif
        .HOLD_FRAMES    (HOLD_FRAMES)
    ) u_banner_scroller (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (win_start),
        .rearm         (rearm),
        .frame_tick    (frame_tick),
`ifdef BANNER_SCROLL_EN
        .scroll_en     (state_q == ENDGAME_SCROLL),
        .scroll_done_c (scroll_done_c),
`endif
        .hold_en       (state_q == ENDGAME_HOLD),
        .hold_done_c   (hold_done_c),
        .start_y       (start_y)
    );

    assign score_p1       = score_p1_q;
    assign score_p2       = score_p2_q;
    assign who_win        = who_win_q;
    assign game_active    = game_active_q;
    assign endgame_active = endgame_active_q;
    assign start_x        = coord_t'(BANNER_X);

endmodule

// File: tb/tb_endgame_controller.sv
// Bench for endgame_controller: vector table, directed corner sequences and random play vs a model.
module tb_endgame_controller;

    localparam int WIN  = 5;
    localparam int HOLD = 120;
    localparam int YS   = 0;
    localparam int YE   = 200;
    localparam int STEP = 4;
    localparam int BX   = 240;

    logic       clk;
    logic       rst_n;
    logic       frame_tick, point_p1, point_p2, restart;
    logic [3:0] score_p1, score_p2;
    logic       game_active, endgame_active;
    logic [1:0] who_win;
    logic [9:0] start_x, start_y;

    endgame_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .point_p1       (point_p1),
        .point_p2       (point_p2),
        .restart        (restart),
        .score_p1       (score_p1),
        .score_p2       (score_p2),
        .game_active    (game_active),
        .endgame_active (endgame_active),
        .who_win        (who_win),
        .start_x        (start_x),
        .start_y        (start_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model phase: 0 playing, 1 banner scrolling, 2 holding, 3 waiting for restart.
    int m_mode, m_s1, m_s2, m_who, m_y, m_hold;

    typedef struct {
        bit p1, p2, rs, ft;
        int e_s1, e_s2, e_game;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_s1 = 0; m_s2 = 0; m_who = 0; m_y = YS; m_hold = 0;
    endtask

    task automatic model_win(input int who);
        m_who = who;
        m_hold = 0;
`ifdef BANNER_SCROLL_EN
        m_mode = 1; m_y = YS;
`else
        m_mode = 2; m_y = YE;
`endif
    endtask

    task automatic model_step(input bit a, input bit b, input bit r, input bit t);
        case (m_mode)
            0: begin
                if (r) begin
                    m_s1 = 0; m_s2 = 0;
                end else if (a && !b) begin
                    m_s1++;
                    if (m_s1 == WIN) model_win(1);
                end else if (b && !a) begin
                    m_s2++;
                    if (m_s2 == WIN) model_win(2);
                end
            end
            1: if (t) begin
                m_y = (m_y + STEP > YE) ? YE : m_y + STEP;
                if (m_y == YE) begin m_mode = 2; m_hold = 0; end
            end
            2: if (t) begin
                if (m_hold == HOLD - 1) m_mode = 3;
                else m_hold++;
            end
            default: if (r) begin
                m_s1 = 0; m_s2 = 0; m_who = 0; m_y = YS; m_mode = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_score_p1"}, int'(score_p1), m_s1);
        chk({tag, "_score_p2"}, int'(score_p2), m_s2);
        chk({tag, "_who_win"}, int'(who_win), m_who);
        chk({tag, "_game_active"}, int'(game_active), (m_mode == 0) ? 1 : 0);
        chk({tag, "_endgame_active"}, int'(endgame_active), (m_mode != 0) ? 1 : 0);
        chk({tag, "_start_x"}, int'(start_x), BX);
        chk({tag, "_start_y"}, int'(start_y), m_y);
    endtask

    task automatic cycle(input bit a, input bit b, input bit r, input bit t, input string tag);
        point_p1 = a; point_p2 = b; restart = r; frame_tick = t;
        @(posedge clk);
        model_step(a, b, r, t);
        #1;
        check_all(tag);
    endtask

    initial begin
        vt[0] = '{1, 0, 0, 0, 1, 0, 1};
        vt[1] = '{0, 1, 0, 0, 1, 1, 1};
        vt[2] = '{1, 1, 0, 0, 1, 1, 1};
        vt[3] = '{0, 0, 0, 1, 1, 1, 1};
        vt[4] = '{1, 0, 1, 0, 0, 0, 1};
        vt[5] = '{0, 1, 0, 0, 0, 1, 1};
        vt[6] = '{0, 1, 1, 0, 0, 0, 1};
        vt[7] = '{1, 0, 0, 0, 1, 0, 1};

        rst_n = 1'b0; point_p1 = 0; point_p2 = 0; restart = 0; frame_tick = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single-cycle play rules.
        for (int i = 0; i < 8; i++) begin
            cycle(vt[i].p1, vt[i].p2, vt[i].rs, vt[i].ft, "vec");
            chk("vec_s1", int'(score_p1), vt[i].e_s1);
            chk("vec_s2", int'(score_p2), vt[i].e_s2);
            chk("vec_game", int'(game_active), vt[i].e_game);
        end
        cycle(0, 0, 1, 0, "clear");

        // P1 wins with five pulses.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, "p1win");
        chk("win_score_p1", int'(score_p1), 5);
        chk("win_who", int'(who_win), 1);
        chk("win_endgame", int'(endgame_active), 1);
        chk("win_game", int'(game_active), 0);
`ifdef BANNER_SCROLL_EN
        chk("win_start_y", int'(start_y), 0);
        for (int k = 1; k <= 50; k++) begin
            cycle(0, 0, 0, 1, "scroll");
            chk("scroll_y", int'(start_y), k * 4);
        end
        cycle(0, 0, 0, 1, "scroll_sat");
        chk("scroll_sat_y", int'(start_y), 200);
        for (int k = 1; k < 119; k++) cycle(0, 0, 1, 1, "hold_lock");
`else
        chk("win_start_y", int'(start_y), 200);
        for (int k = 0; k < 119; k++) cycle(0, 0, 1, 1, "hold_lock");
`endif
        chk("hold_lock_game", int'(game_active), 0);
        chk("hold_lock_score", int'(score_p1), 5);
        cycle(0, 0, 0, 1, "hold_last");
        cycle(0, 0, 1, 0, "restart");
        chk("restart_game", int'(game_active), 1);
        chk("restart_who", int'(who_win), 0);
        chk("restart_y", int'(start_y), 0);

        // 4:4, simultaneous points dropped, then P2 wins.
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, "tie");
            cycle(0, 1, 0, 0, "tie");
        end
        cycle(1, 1, 0, 0, "both");
        chk("both_s1", int'(score_p1), 4);
        chk("both_s2", int'(score_p2), 4);
        cycle(0, 1, 0, 0, "p2win");
        chk("p2win_who", int'(who_win), 2);
        chk("p2win_s2", int'(score_p2), 5);
        for (int k = 0; k < 400 && m_mode != 3; k++) cycle(0, 0, 0, 1, "p2end");
        chk("p2end_reached_wait", m_mode, 3);
        cycle(0, 0, 1, 0, "p2restart");

        // Asynchronous reset in the middle of the endgame.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, "arst_win");
        for (int k = 0; k < 25; k++) cycle(0, 0, 0, 1, "arst_run");
`ifdef BANNER_SCROLL_EN
        chk("arst_pre_y", int'(start_y), 100);
`endif
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        chk("arst_game", int'(game_active), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Random play against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 64) == 0,
                  ($urandom % 2) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
